// File: rtl/frame_stream_sequencer.sv
// frame_stream_sequencer: receives one frame of DATA_W-bit words as UART bytes,
// passes it through a valid/ready core (or copies it when bypassed), and sends
// the results back out as UART bytes, least-significant byte first.
// Ports:
//   clk_i, rst_i (asynchronous, active-high), en_i (global freeze)
//   start_i, bypass_i, unload_i, abort_i   frame control
//   rx_valid_i, rx_data_i                  received bytes
//   tx_full_i, tx_wr_o, tx_data_o          transmitted bytes
//   core_en_o, core_valid_o, core_data_o, core_ready_i   words to the core
//   res_valid_i, res_data_i, res_ready_o   results from the core
//   state_o, busy_o, loaded_o, done_o, err_o, frame_cnt_o   status
module frame_stream_sequencer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 76800,
    parameter int ADDR_W = 17
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              start_i,
    input  logic              bypass_i,
    input  logic              unload_i,
    input  logic              abort_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    input  logic              tx_full_i,
    output logic              tx_wr_o,
    output logic [7:0]        tx_data_o,
    output logic              core_en_o,
    output logic              core_valid_o,
    output logic [DATA_W-1:0] core_data_o,
    input  logic              core_ready_i,
    input  logic              res_valid_i,
    input  logic [DATA_W-1:0] res_data_i,
    output logic              res_ready_o,
    output logic [2:0]        state_o,
    output logic              busy_o,
    output logic              loaded_o,
    output logic              done_o,
    output logic              err_o,
    output logic [15:0]       frame_cnt_o
);
    localparam int NB = (DATA_W + 7) / 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] DEP = CW'(DEPTH);
    localparam logic [BW-1:0] BLAST = BW'(NB - 1);

    typedef enum logic [2:0] {IDLE, LOAD, PROC, COPY, WAIT, UNLOAD, DONE} state_t;
    state_t st, st_n;

    logic [DATA_W-1:0] in_mem [DEPTH];
    logic [DATA_W-1:0] out_mem [DEPTH];
    logic [DATA_W-1:0] in_rd, out_rd, rdata, cd_q, sd_q;
    logic [NB*8-1:0] asm_q, txw;
    logic [CW-1:0] wcnt, ra, rcnt;
    logic [BW-1:0] bcnt, tcnt;
    logic [15:0] frame_q;
    logic [1:0] occ;
    logic we_q, cv_q, sv_q, pend_q, bypass_q, done_q, err_q;
    logic start_acc, rx_in, rx_last, wr_in, res_acc, tx_wr, tlast, acc, iss;
    logic load_done, proc_done, copy_done, unl_done, out_we;

    // cd_q/cv_q is the word on offer (to the core in PROC, to the byte
    // serialiser in UNLOAD); sd_q/sv_q is a skid slot so a read already in
    // flight always has somewhere to land, giving one word per cycle.
    always_comb begin
        start_acc = st == IDLE && start_i && !abort_i;
        rx_in     = st == LOAD && rx_valid_i;
        rx_last   = rx_in && bcnt == BLAST;
        wr_in     = st == LOAD && we_q;
        res_acc   = st == PROC && res_valid_i;
        tlast     = tcnt == BLAST;
        tx_wr     = st == UNLOAD && cv_q && !tx_full_i;
        acc       = st == PROC ? cv_q && core_ready_i : tx_wr && tlast;
        occ       = 2'(cv_q) + 2'(sv_q) + 2'(pend_q);
        iss       = ra < DEP && (st == COPY || ((st == PROC || st == UNLOAD) && occ - 2'(acc) < 2'd2));
        load_done = wr_in && wcnt == LAST;
        proc_done = res_acc && rcnt == LAST;
        copy_done = st == COPY && pend_q && rcnt == LAST;
        unl_done  = tx_wr && tlast && rcnt == LAST;
        out_we    = res_acc || (st == COPY && pend_q);
        rdata     = st == UNLOAD ? out_rd : in_rd;
        txw       = (NB*8)'(cd_q);
    end

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    st_n = start_i ? LOAD : IDLE;
            LOAD:    st_n = load_done ? (bypass_q ? COPY : PROC) : LOAD;
            PROC:    st_n = proc_done ? WAIT : PROC;
            COPY:    st_n = copy_done ? WAIT : COPY;
            WAIT:    st_n = unload_i ? UNLOAD : WAIT;
            UNLOAD:  st_n = unl_done ? DONE : UNLOAD;
            default: st_n = IDLE;
        endcase
        if (abort_i) st_n = IDLE;
        if (!en_i) st_n = st;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) st <= IDLE;
        else st <= st_n;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            {wcnt, ra, rcnt, bcnt, tcnt, frame_q, asm_q, cd_q, sd_q} <= '0;
            {we_q, cv_q, sv_q, pend_q, bypass_q, done_q, err_q} <= '0;
        end else if (en_i) begin
            err_q <= !start_acc && (err_q || (rx_valid_i && st != LOAD) || (res_valid_i && st != PROC));
            if (start_acc) begin
                bypass_q <= bypass_i;
                done_q   <= 1'b0;
            end
            if (unl_done && !abort_i) begin
                done_q  <= 1'b1;
                frame_q <= frame_q + 16'd1;
            end
            // WAIT rewinds the read side so UNLOAD starts from word 0 with an empty pipeline.
            if (abort_i || start_acc || st == WAIT) begin
                {wcnt, ra, rcnt, bcnt, tcnt} <= '0;
                {we_q, cv_q, sv_q, pend_q} <= '0;
            end else begin
                we_q   <= rx_last;
                pend_q <= iss;
                if (rx_in) begin
                    asm_q[bcnt*8 +: 8] <= rx_data_i;
                    bcnt <= rx_last ? '0 : bcnt + 1'b1;
                end
                if (wr_in) wcnt <= wcnt + 1'b1;
                if (iss) ra <= ra + 1'b1;
                if (out_we || (tx_wr && tlast)) rcnt <= rcnt + 1'b1;
                if (tx_wr) tcnt <= tlast ? '0 : tcnt + 1'b1;
                if ((st == PROC || st == UNLOAD) && (acc || !cv_q)) begin
                    cv_q <= sv_q | pend_q;
                    cd_q <= sv_q ? sd_q : rdata;
                    sv_q <= sv_q & pend_q;
                    sd_q <= rdata;
                end else if ((st == PROC || st == UNLOAD) && pend_q) begin
                    sv_q <= 1'b1;
                    sd_q <= rdata;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (wr_in) in_mem[wcnt[ADDR_W-1:0]] <= asm_q[DATA_W-1:0];
            if (out_we) out_mem[rcnt[ADDR_W-1:0]] <= st == COPY ? in_rd : res_data_i;
            in_rd  <= in_mem[ra[ADDR_W-1:0]];
            out_rd <= out_mem[ra[ADDR_W-1:0]];
        end
    end

    assign tx_wr_o      = en_i && tx_wr;
    assign tx_data_o    = txw[tcnt*8 +: 8];
    assign core_en_o    = st == PROC;
    assign core_valid_o = en_i && st == PROC && cv_q;
    assign core_data_o  = cd_q;
    assign res_ready_o  = en_i && st == PROC;
    assign state_o      = st;
    assign busy_o       = st != IDLE;
    assign loaded_o     = st == PROC || st == WAIT;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign frame_cnt_o  = frame_q;
endmodule

// File: tb/tb_frame_stream_sequencer.sv
// tb_frame_stream_sequencer: directed frames with random data, random handshakes
// and enable gaps, checked against a word/byte-level model of the frame flow.
module tb_frame_stream_sequencer;
    localparam int DW = 12;
    localparam int DP = 4;
    localparam int AW = 2;
    localparam int NB = (DW + 7) / 8;

    logic clk_i = 0, rst_i = 1, en_i = 0, start_i = 0, bypass_i = 0, unload_i = 0, abort_i = 0;
    logic rx_valid_i = 0, tx_full_i = 0, core_ready_i = 0, res_valid_i = 0;
    logic [7:0] rx_data_i = 0;
    logic [DW-1:0] res_data_i = 0;
    logic tx_wr_o, core_en_o, core_valid_o, res_ready_o, busy_o, loaded_o, done_o, err_o;
    logic [7:0] tx_data_o;
    logic [DW-1:0] core_data_o;
    logic [2:0] state_o;
    logic [15:0] frame_cnt_o;

    int errors = 0, checks = 0, frames = 0, cyc = 0;
    int rmode = 0, fmode = 0, stall_left = 0, in_idx = 0, tx_idx = 0;
    bit res_rand = 0, rand_en = 0, stalled = 0, no_tx = 0;
    logic [7:0] fb [DP*NB];
    logic [DW-1:0] exp_in [$];
    logic [DW-1:0] core_q [$];
    logic [7:0] exp_tx [$];

    frame_stream_sequencer #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .start_i(start_i), .bypass_i(bypass_i),
        .unload_i(unload_i), .abort_i(abort_i), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
        .tx_full_i(tx_full_i), .tx_wr_o(tx_wr_o), .tx_data_o(tx_data_o), .core_en_o(core_en_o),
        .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_ready_i(core_ready_i),
        .res_valid_i(res_valid_i), .res_data_i(res_data_i), .res_ready_o(res_ready_o),
        .state_o(state_o), .busy_o(busy_o), .loaded_o(loaded_o), .done_o(done_o), .err_o(err_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Word value = little-endian bytes modulo 2^DW; the core adds 1 modulo 2^DW.
    task automatic load_model(input bit byp);
        int v, r;
        exp_in.delete(); exp_tx.delete(); core_q.delete();
        in_idx = 0; tx_idx = 0; stall_left = 5; stalled = 0;
        for (int i = 0; i < DP; i++) begin
            v = 0;
            for (int k = 0; k < NB; k++) v += int'(fb[i*NB+k]) * (1 << (8 * k));
            v = v % (1 << DW);
            exp_in.push_back(DW'(v));
            r = byp ? v : (v + 1) % (1 << DW);
            for (int k = 0; k < NB; k++) exp_tx.push_back(8'((r >> (8 * k)) % 256));
        end
    endtask

    // Core, result source and transmit FIFO model; drives at negedge, samples 1ns later.
    always @(negedge clk_i) begin
        cyc++;
        core_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
        res_valid_i = core_q.size() > 0 && (!res_rand || $urandom_range(0, 1) == 1);
        res_data_i = core_q.size() > 0 ? core_q[0] : '0;
        tx_full_i = fmode == 1 ? (tx_idx == 2 && stall_left > 0) : fmode == 2 ? $urandom_range(0, 3) == 0 : 1'b0;
        if (fmode == 1 && tx_full_i) stall_left--;
        #1;
        if (no_tx) chk("no_tx_after_rst", 32'(tx_wr_o), 0);
        else if (!rst_i) begin
            if (!en_i) chk("strobes_when_disabled", 32'({tx_wr_o, core_valid_o, res_ready_o}), 0);
            if (stalled && en_i) chk("core_valid_hold", 32'(core_valid_o), 1);
            if (en_i) stalled = core_valid_o && !core_ready_i;
            if (core_valid_o) begin
                chk("core_in_range", 32'(in_idx < DP), 1);
                if (in_idx < DP) chk("core_in_word", 32'(core_data_o), 32'(exp_in[in_idx]));
            end
            if (core_valid_o && core_ready_i && in_idx < DP) begin
                core_q.push_back(DW'(exp_in[in_idx] + 1));
                in_idx++;
            end
            if (res_valid_i && res_ready_o) void'(core_q.pop_front());
            if (tx_wr_o) begin
                chk("tx_while_full", 32'(tx_full_i), 0);
                chk("tx_in_range", 32'(tx_idx < exp_tx.size()), 1);
                if (tx_idx < exp_tx.size()) chk("tx_byte", 32'(tx_data_o), 32'(exp_tx[tx_idx]));
                tx_idx++;
            end
        end
    end

    function automatic bit reached(input int what);
        return what == 7 ? done_o : int'(state_o) == what;
    endfunction

    task automatic waitfor(input int what, input int budget, input string tag);
        for (int i = 0; i < budget && !reached(what); i++) begin
            en_i = rand_en ? $urandom_range(0, 4) != 0 : 1'b1;
            @(negedge clk_i);
        end
        en_i = 1;
        chk(tag, 32'(reached(what)), 1);
    endtask

    task automatic send(input logic [7:0] b);
        if (rand_en && $urandom_range(0, 2) == 0) begin
            en_i = 0;
            @(negedge clk_i);
        end
        en_i = 1; rx_valid_i = 1; rx_data_i = b;
        @(negedge clk_i);
        rx_valid_i = 0;
    endtask

    task automatic begin_frame(input bit byp);
        load_model(byp);
        en_i = 1; start_i = 1; bypass_i = byp;
        @(negedge clk_i);
        start_i = 0;
        chk("start_to_load", 32'(state_o), 1);
        chk("start_clears_err", 32'(err_o), 0);
        chk("start_clears_done", 32'(done_o), 0);
    endtask

    task automatic run_frame(input bit byp, input bit probe);
        begin_frame(byp);
        foreach (fb[i]) send(fb[i]);
        waitfor(4, 300, "reach_wait");
        chk("loaded_in_wait", 32'(loaded_o), 1);
        chk("core_word_count", 32'(in_idx), byp ? 0 : DP);
        if (probe) begin
            rx_valid_i = 1; start_i = 1;
            @(negedge clk_i);
            rx_valid_i = 0; start_i = 0;
            chk("stray_rx_sets_err", 32'(err_o), 1);
            chk("start_ignored_in_wait", 32'(state_o), 4);
        end
        unload_i = 1;
        waitfor(7, 400, "reach_done");
        unload_i = 0;
        frames++;
        chk("tx_byte_total", 32'(tx_idx), DP * NB);
        chk("frame_count", 32'(frame_cnt_o), 32'(frames));
        chk("err_at_end", 32'(err_o), 32'(probe));
        @(negedge clk_i);
        chk("back_to_idle", 32'(busy_o), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_flags", 32'({busy_o, loaded_o, done_o, err_o}), 0);
        chk("rst_strobes", 32'({tx_wr_o, core_en_o, core_valid_o, res_ready_o}), 0);
        chk("rst_frames", 32'(frame_cnt_o), 0);
        rst_i = 0; en_i = 1;
        @(negedge clk_i);
        // Basic frame through the core.
        foreach (fb[i]) fb[i] = 8'($urandom);
        run_frame(0, 0);
        // Multi-byte bypass with discarded/zeroed high bits.
        fb = '{8'hBC, 8'hFA, 8'h34, 8'h12, 8'h78, 8'hF6, 8'h01, 8'h00};
        run_frame(1, 0);
        // Core backpressure 1,0,0,1.
        foreach (fb[i]) fb[i] = 8'($urandom);
        rmode = 1;
        run_frame(0, 0);
        // TX stall of 5 cycles after the 2nd byte.
        rmode = 0; fmode = 1;
        foreach (fb[i]) fb[i] = 8'($urandom);
        run_frame(0, 0);
        fmode = 0;
        // Abort mid-load, abort over start, then a clean frame.
        foreach (fb[i]) fb[i] = 8'($urandom);
        begin_frame(0);
        send(fb[0]); send(fb[1]);
        abort_i = 1;
        @(negedge clk_i);
        abort_i = 0;
        chk("abort_state", 32'(state_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_frames", 32'(frame_cnt_o), 32'(frames));
        chk("abort_no_done", 32'(done_o), 0);
        abort_i = 1; start_i = 1;
        @(negedge clk_i);
        abort_i = 0; start_i = 0;
        chk("abort_over_start", 32'(state_o), 0);
        foreach (fb[i]) fb[i] = 8'($urandom);
        run_frame(0, 0);
        // Random handshakes, enable gaps and a stray byte in WAIT.
        rand_en = 1; rmode = 2; fmode = 2; res_rand = 1;
        for (int f = 0; f < 3; f++) begin
            foreach (fb[i]) fb[i] = 8'($urandom);
            run_frame(f == 1, f != 1);
        end
        rand_en = 0; rmode = 0; fmode = 0; res_rand = 0;
        // Asynchronous reset in the middle of UNLOAD.
        foreach (fb[i]) fb[i] = 8'($urandom);
        begin_frame(0);
        foreach (fb[i]) send(fb[i]);
        waitfor(4, 300, "reach_wait_rst");
        unload_i = 1;
        for (int i = 0; i < 50 && tx_idx < 3; i++) @(negedge clk_i);
        chk("tx_started_before_rst", 32'(tx_idx >= 3), 1);
        #3 rst_i = 1;
        #1;
        chk("async_rst_state", 32'(state_o), 0);
        chk("async_rst_strobes", 32'({tx_wr_o, core_valid_o, res_ready_o, busy_o, done_o}), 0);
        chk("async_rst_txdata", 32'(tx_data_o), 0);
        chk("async_rst_frames", 32'(frame_cnt_o), 0);
        no_tx = 1;
        repeat (5) @(negedge clk_i);
        rst_i = 0;
        repeat (5) @(negedge clk_i);
        chk("idle_after_rst", 32'(state_o), 0);
        unload_i = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/frame_stream_sequencer.md
# frame_stream_sequencer

- Parametrised frame sequencer for the UART image path:
  - Loads one frame of DEPTH words, each DATA_W bits wide, from the UART receive side into an input buffer.
  - Streams the frame through a processing core with valid/ready handshakes, collecting results into an output buffer.
  - Sends the results back out through the UART transmit side.
- Generalises the fixed 8-bit, 76800-entry receive/process/send flow:
  - multi-byte words;
  - a core-bypass mode;
  - abort;
  - error reporting;
  - a frame counter.

## Interface
- DATA_W, 8: word width. Words are carried as ceil(DATA_W/8) UART bytes, least-significant byte first.
- DEPTH, 76800: words per frame, minimum 2.
- ADDR_W, 17: buffer address width. Required: 2^ADDR_W >= DEPTH.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- en_i  in  1  global enable. When low, all state freezes and strobe outputs are 0.
- start_i  in  1  start pulse; accepted only in IDLE.
- bypass_i  in  1  sampled on an accepted start_i. When 1, the core is skipped and the output buffer is a copy of the input.
- unload_i  in  1  level; permission to begin transmitting.
- abort_i  in  1  return to IDLE.
- rx_valid_i  in  1  one-cycle strobe: rx_data_i holds a received byte.
- rx_data_i  in  8  received byte.
- tx_full_i  in  1  transmit FIFO full.
- tx_wr_o  out  1  transmit write strobe.
- tx_data_o  out  8  transmit byte.
- core_en_o  out  1  high during PROC.
- core_valid_o  out  1  input word valid to core.
- core_data_o  out  DATA_W  input word to core.
- core_ready_i  in  1  core accepts input word.
- res_valid_i  in  1  core result valid.
- res_data_i  in  DATA_W  core result word.
- res_ready_o  out  1  block accepts result.
- state_o  out  3  current state encoding.
- busy_o  out  1  state != IDLE.
- loaded_o  out  1  high in PROC and WAIT.
- done_o  out  1  sticky; cleared by the next accepted start_i.
- err_o  out  1  sticky; cleared by the next accepted start_i.
- frame_cnt_o  out  16  completed frames; wraps at 65535.

## Operation
- **Buffers.** Two internal inferred RAMs, DEPTH x DATA_W, with synchronous read (1-cycle latency).
- **States and transitions:**
  - IDLE (0): start_i -> LOAD.
  - LOAD (1): assemble bytes into a word; write the word at wcnt after its last byte; wcnt+1. When wcnt reaches DEPTH -> PROC, or -> COPY if bypass.
  - PROC (2): feed input words in address order; accept results into the output buffer in arrival order. When the result count reaches DEPTH -> WAIT.
  - COPY (3): copy the input buffer to the output buffer word by word. After DEPTH words -> WAIT.
  - WAIT (4): wait for unload_i=1 -> UNLOAD.
  - UNLOAD (5): read each word; emit its bytes LSB first, one per tx_wr_o. After the last byte of word DEPTH-1 -> DONE.
  - DONE (6): done_o <= 1; frame_cnt_o + 1; -> IDLE next cycle.
- **Width rule.** If DATA_W is not a multiple of 8:
  - on load, the unused high bits of the last byte are discarded;
  - on unload, they are transmitted as 0.
- **Core handshake.** A transfer occurs in a cycle where valid && ready.
  - core_valid_o and core_data_o hold stable until accepted.
  - A prefetch register hides the read latency.
- **TX rule.** tx_wr_o is asserted only when tx_full_i=0. A full FIFO stalls emission with no byte lost or duplicated.
- **Boundary behaviour:**
  - rx_valid_i outside LOAD: byte dropped, err_o <= 1.
  - res_valid_i outside PROC: result ignored, err_o <= 1.
  - res_ready_o is 0 outside PROC.
  - start_i outside IDLE: ignored.
  - abort_i in any state: next cycle IDLE, all counters cleared, no done_o pulse, frame_cnt_o unchanged. abort_i has priority over start_i.
  - Word counters never exceed DEPTH. No address wrap-around within a frame.
  - en_i low mid-frame: resume exactly where frozen. An rx_valid_i strobe while en_i is low is lost and is not flagged.

## Timing
- **Reset values.** All outputs 0; state IDLE; counters 0. Buffer contents undefined.
- **start_i to LOAD.** start_i sampled at edge N gives state_o=1 after edge N.
- **LOAD.** A word is written the cycle after its last byte strobe. Bytes may arrive on consecutive cycles.
- **PROC input.** core_valid_o rises within 2 cycles of entering PROC. With core_ready_i held 1, one word is accepted per cycle.
- **PROC results.** res_ready_o=1 throughout PROC.
- **COPY.** DEPTH+1 cycles.
- **UNLOAD.**
  - First tx_wr_o is at most 2 cycles after entering UNLOAD with tx_full_i=0.
  - With tx_full_i=0, one byte per cycle.
- **DONE.** done_o rises the cycle after the last tx_wr_o. frame_cnt_o increments at the same edge.

## Test plan
- **Basic frame.** DATA_W=8, DEPTH=4. Bytes 11,22,33,44, then core returns each word plus 1, unload_i=1. Required: tx bytes 12,23,34,45; done_o=1; frame_cnt_o=1; err_o=0.
- **Multi-byte words.** DATA_W=12, DEPTH=2, bypass. Bytes 0xBC,0xFA,0x34,0x12. Required: tx bytes 0xBC,0x0A,0x34,0x02.
- **Core backpressure.** core_ready_i toggles 1,0,0,1. Required: core_data_o stable while stalled; core inputs in address order 0..3, none skipped or duplicated.
- **TX stall.** tx_full_i high for 5 cycles after the 2nd byte. Required: no tx_wr_o during the stall; all 4 bytes sent exactly once, in order.
- **Abort mid-load.** abort_i after 2 of 4 bytes. Required:
  - IDLE next cycle, busy_o=0, frame_cnt_o unchanged;
  - a restart then loads from address 0 correctly.
- **Errors and reset.**
  - A stray rx_valid_i in WAIT gives err_o=1; the next start_i clears it.
  - rst_i asserted mid-UNLOAD: all outputs 0 immediately (asynchronous), with no further tx_wr_o.
